// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared bus widths, load opcodes and bus payload layouts
// for the MEM stage and its neighbours.
package mem_stage_pkg;

    localparam int unsigned TO_MEM_DATA_WIDTH = 74;
    localparam int unsigned TO_WB_DATA_WIDTH  = 70;
    localparam int unsigned FORWRD_DATA_WIDTH = 37;
    localparam int unsigned WORD_WIDTH        = 32;
    localparam int unsigned REG_ADDR_WIDTH    = 5;
    localparam int unsigned LD_OP_WIDTH       = 3;

    // Load opcodes carried in the EX->MEM payload; 101..111 behave as ld.w.
    localparam logic [LD_OP_WIDTH-1:0] LD_W  = 3'b000;
    localparam logic [LD_OP_WIDTH-1:0] LD_B  = 3'b001;
    localparam logic [LD_OP_WIDTH-1:0] LD_H  = 3'b010;
    localparam logic [LD_OP_WIDTH-1:0] LD_BU = 3'b011;
    localparam logic [LD_OP_WIDTH-1:0] LD_HU = 3'b100;

    // EX -> MEM payload, MSB first.
    typedef struct packed {
        logic [WORD_WIDTH-1:0]     pc;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic [WORD_WIDTH-1:0]     alu_result;
        logic                      gr_we;
        logic                      res_from_mem;
        logic [LD_OP_WIDTH-1:0]    ld_op;
    } ex_mem_bus_t;

    // MEM -> WB payload, MSB first.
    typedef struct packed {
        logic [WORD_WIDTH-1:0]     pc;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic [WORD_WIDTH-1:0]     final_result;
        logic                      gr_we;
    } mem_wb_bus_t;

    // MEM -> ID bypass payload; dest 0 means nothing to forward.
    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] fwd_dest;
        logic [WORD_WIDTH-1:0]     final_result;
    } mem_fwd_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/halfword of a memory word and
// sign- or zero-extends it according to the load opcode.
//   mem_word  in  32  raw word returned by the data SRAM
//   addr      in  2   low address bits of the load
//   ld_op     in  3   load opcode
//   load_data out 32  aligned, extended load result
module load_align
    import mem_stage_pkg::*;
(
    input  logic [WORD_WIDTH-1:0]  mem_word,
    input  logic [1:0]             addr,
    input  logic [LD_OP_WIDTH-1:0] ld_op,
    output logic [WORD_WIDTH-1:0]  load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte lane selected by addr; halfword lane by addr[1] only (addr[0] ignored).
    always_comb begin
        byte_sel = mem_word[7:0];
        case (addr)
            2'd0: byte_sel = mem_word[7:0];
            2'd1: byte_sel = mem_word[15:8];
            2'd2: byte_sel = mem_word[23:16];
            2'd3: byte_sel = mem_word[31:24];
            default: byte_sel = mem_word[7:0];
        endcase
        half_sel = addr[1] ? mem_word[31:16] : mem_word[15:0];
    end

    // Extension by opcode; unlisted codes fall back to the whole word.
    always_comb begin
        load_data = mem_word;
        case (ld_op)
            LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_data = {24'd0, byte_sel};
            LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_data = {16'd0, half_sel};
            default: load_data = mem_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. Registers one instruction from
// EX under a valid/allow-in handshake, combines its ALU result or the
// aligned SRAM load word into the writeback bus, and drives the ID bypass.
//   clk, reset        clock, synchronous active-high reset
//   to_MEM_data       in  74  EX payload {pc, dest, alu_result, gr_we, res_from_mem, ld_op}
//   EX_to_MEM_valid   in  1   EX holds a valid instruction
//   MEM_allow_in      out 1   MEM accepts from EX this cycle
//   data_sram_rdata   in  32  SRAM read data, valid in the first cycle after accept
//   to_WB_data        out 70  {pc, dest, final_result, gr_we}
//   MEM_to_WB_valid   out 1   MEM presents a valid instruction
//   WB_allow_in       in  1   WB accepts this cycle
//   MEM_forward       out 37  {fwd_dest, final_result}
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [TO_MEM_DATA_WIDTH-1:0] to_MEM_data,
    input  logic                         EX_to_MEM_valid,
    output logic                         MEM_allow_in,
    input  logic [WORD_WIDTH-1:0]        data_sram_rdata,
    output logic [TO_WB_DATA_WIDTH-1:0]  to_WB_data,
    output logic                         MEM_to_WB_valid,
    input  logic                         WB_allow_in,
    output logic [FORWRD_DATA_WIDTH-1:0] MEM_forward
);

    ex_mem_bus_t           mem_q;
    logic                  mem_valid;
    logic                  first_cycle;
    logic [WORD_WIDTH-1:0] rdata_buf;
    logic                  accept;
    logic [WORD_WIDTH-1:0] mem_word;
    logic [WORD_WIDTH-1:0] load_data;
    logic [WORD_WIDTH-1:0] final_result;
    mem_wb_bus_t           wb_bus;
    mem_fwd_bus_t          fwd_bus;

    // ready_go is always 1, so MEM can take a new instruction whenever the
    // current one (if any) leaves this cycle.
    assign MEM_allow_in    = ~mem_valid | WB_allow_in;
    assign MEM_to_WB_valid = mem_valid;
    assign accept          = EX_to_MEM_valid & MEM_allow_in;

    // Handshake state; first_cycle marks the cycle SRAM data is live.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid   <= 1'b0;
            first_cycle <= 1'b0;
        end else begin
            if (MEM_allow_in) begin
                mem_valid <= EX_to_MEM_valid;
            end
            first_cycle <= accept;
        end
    end

    // Payload register; contents are don't-care while the stage is empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q <= ex_mem_bus_t'(to_MEM_data);
        end
    end

    // Capture the SRAM word if WB stalls during its only valid cycle, so the
    // load result stays stable for the rest of the stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf <= '0;
        end else if (first_cycle & mem_valid & ~WB_allow_in) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    assign mem_word = first_cycle ? data_sram_rdata : rdata_buf;

    load_align u_load_align (
        .mem_word  (mem_word),
        .addr      (mem_q.alu_result[1:0]),
        .ld_op     (mem_q.ld_op),
        .load_data (load_data)
    );

    assign final_result = mem_q.res_from_mem ? load_data : mem_q.alu_result;

    // Writeback and bypass buses; bypass dest masked to 0 when nothing writes.
    always_comb begin
        wb_bus              = '0;
        wb_bus.pc           = mem_q.pc;
        wb_bus.dest         = mem_q.dest;
        wb_bus.final_result = final_result;
        wb_bus.gr_we        = mem_q.gr_we;

        fwd_bus              = '0;
        fwd_bus.fwd_dest     = (mem_valid & mem_q.gr_we) ? mem_q.dest : REG_ADDR_WIDTH'(0);
        fwd_bus.final_result = final_result;
    end

    assign to_WB_data  = TO_WB_DATA_WIDTH'(wb_bus);
    assign MEM_forward = FORWRD_DATA_WIDTH'(fwd_bus);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a
// transaction-level model of the stage contents.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [73:0] to_MEM_data;
    logic        EX_to_MEM_valid;
    logic        MEM_allow_in;
    logic [31:0] data_sram_rdata;
    logic [69:0] to_WB_data;
    logic        MEM_to_WB_valid;
    logic        WB_allow_in;
    logic [36:0] MEM_forward;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .to_MEM_data     (to_MEM_data),
        .EX_to_MEM_valid (EX_to_MEM_valid),
        .MEM_allow_in    (MEM_allow_in),
        .data_sram_rdata (data_sram_rdata),
        .to_WB_data      (to_WB_data),
        .MEM_to_WB_valid (MEM_to_WB_valid),
        .WB_allow_in     (WB_allow_in),
        .MEM_forward     (MEM_forward)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: what instruction sits in MEM, and the memory word it loaded.
    logic        m_valid = 1'b0;
    logic        m_first = 1'b0;
    logic [73:0] m_ins   = '0;
    logic [31:0] m_word  = '0;

    // Inputs applied this cycle, consumed by the model at the next edge.
    logic        c_rst, c_exv, c_wb;
    logic [73:0] c_din;

    function automatic logic [73:0] mk(input logic [31:0] pc, input logic [4:0] dest,
                                       input logic [31:0] alu, input logic gr_we,
                                       input logic rfm, input logic [2:0] op);
        return {pc, dest, alu, gr_we, rfm, op};
    endfunction

    // Load result from the ISA definition: shift the lane down, then extend.
    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * a));
        h = 16'(w >> (16 * a[1]));
        case (op)
            3'b001:  return 32'($signed(b));
            3'b011:  return 32'(b);
            3'b010:  return 32'($signed(h));
            3'b100:  return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_result();
        logic [31:0] alu;
        alu = m_ins[36:5];
        return m_ins[3] ? load_val(m_word, alu[1:0], m_ins[2:0]) : alu;
    endfunction

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model comparison, run on every cycle once inputs have settled.
    task automatic compare();
        logic [31:0] res;
        logic [4:0]  fdest;
        chk("valid", 70'(MEM_to_WB_valid), 70'(m_valid));
        chk("allow_in", 70'(MEM_allow_in), 70'(!m_valid || c_wb));
        if (m_valid) begin
            res   = exp_result();
            fdest = m_ins[4] ? m_ins[41:37] : 5'd0;
            chk("to_WB_data", to_WB_data, {m_ins[73:42], m_ins[41:37], res, m_ins[4]});
            chk("forward", 70'(MEM_forward), 70'({fdest, res}));
        end else begin
            chk("fwd_dest_empty", 70'(MEM_forward[36:32]), 70'd0);
        end
    endtask

    task automatic drive(input logic rst, input logic exv, input logic [73:0] din,
                         input logic wb, input logic [31:0] rd);
        @(negedge clk);
        reset           = rst;
        EX_to_MEM_valid = exv;
        to_MEM_data     = din;
        WB_allow_in     = wb;
        data_sram_rdata = rd;
        c_rst = rst; c_exv = exv; c_din = din; c_wb = wb;
        if (m_first) m_word = rd;
        #1;
        compare();
    endtask

    task automatic tick();
        logic allow;
        @(posedge clk);
        allow = !m_valid || c_wb;
        if (c_rst) begin
            m_valid = 1'b0;
            m_first = 1'b0;
        end else begin
            m_first = allow && c_exv;
            if (allow) m_valid = c_exv;
            if (allow && c_exv) m_ins = c_din;
        end
    endtask

    logic [2:0]  lt_op  [5];
    logic [1:0]  lt_a   [5];
    logic [31:0] lt_exp [5];
    logic [31:0] pcs    [4];

    initial begin
        reset = 1'b1; EX_to_MEM_valid = 1'b0; to_MEM_data = '0;
        WB_allow_in = 1'b0; data_sram_rdata = '0;
        c_rst = 1'b1; c_exv = 1'b0; c_wb = 1'b0; c_din = '0;

        // Reset state.
        drive(1, 0, '0, 0, 0); tick();
        drive(1, 0, '0, 0, 0); tick();
        drive(0, 0, '0, 0, 0);
        chk("rst_valid", 70'(MEM_to_WB_valid), 70'd0);
        chk("rst_allow", 70'(MEM_allow_in), 70'd1);
        chk("rst_fwd_dest", 70'(MEM_forward[36:32]), 70'd0);
        tick();

        // ALU passthrough.
        drive(0, 1, mk(32'h1c000000, 5'd5, 32'h12345678, 1, 0, 3'b000), 1, 0); tick();
        drive(0, 0, '0, 1, 32'hA5A5A5A5);
        chk("alu_valid", 70'(MEM_to_WB_valid), 70'd1);
        chk("alu_result", 70'(to_WB_data[32:1]), 70'h12345678);
        chk("alu_fwd_dest", 70'(MEM_forward[36:32]), 70'd5);
        tick();

        // Load extraction against rdata 0x80FF7F01.
        lt_op[0] = 3'b001; lt_a[0] = 2'd3; lt_exp[0] = 32'hFFFFFF80;
        lt_op[1] = 3'b011; lt_a[1] = 2'd3; lt_exp[1] = 32'h00000080;
        lt_op[2] = 3'b010; lt_a[2] = 2'd2; lt_exp[2] = 32'hFFFF80FF;
        lt_op[3] = 3'b100; lt_a[3] = 2'd2; lt_exp[3] = 32'h000080FF;
        lt_op[4] = 3'b000; lt_a[4] = 2'd1; lt_exp[4] = 32'h80FF7F01;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, mk(32'h1c000100 + 32'(i * 4), 5'd9, {30'h00000400, lt_a[i]}, 1, 1, lt_op[i]), 1, 0);
            tick();
            drive(0, 0, '0, 1, 32'h80FF7F01);
            chk("load_ext", 70'(to_WB_data[32:1]), 70'(lt_exp[i]));
            tick();
        end

        // Stall hold: SRAM data only valid in the first cycle.
        drive(0, 1, mk(32'h1c000200, 5'd3, 32'h00000800, 1, 1, 3'b000), 1, 0); tick();
        drive(0, 0, '0, 0, 32'hDEADBEEF);
        chk("stall_res0", 70'(to_WB_data[32:1]), 70'hDEADBEEF);
        chk("stall_allow", 70'(MEM_allow_in), 70'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, mk(32'h1c000300, 5'd4, 32'h0, 1, 0, 3'b000), 0, 0);
            chk("stall_res", 70'(to_WB_data[32:1]), 70'hDEADBEEF);
            chk("stall_allow", 70'(MEM_allow_in), 70'd0);
            tick();
        end
        drive(0, 0, '0, 1, 0);
        chk("stall_release", 70'({MEM_to_WB_valid, to_WB_data[69:38], to_WB_data[32:1]}),
            70'({1'b1, 32'h1c000200, 32'hDEADBEEF}));
        tick();
        drive(0, 0, '0, 1, 0);
        chk("stall_once", 70'(MEM_to_WB_valid), 70'd0);
        tick();

        // Back-to-back accepts.
        for (int i = 0; i < 4; i++) pcs[i] = 32'h1c001000 + 32'(i * 4);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(0, 1, mk(pcs[i], 5'(i + 1), 32'(i), 1, 0, 3'b000), 1, 0);
            else       drive(0, 0, '0, 1, 0);
            if (i > 0) chk("b2b_pc", 70'({MEM_to_WB_valid, to_WB_data[69:38]}), 70'({1'b1, pcs[i - 1]}));
            tick();
        end
        drive(0, 0, '0, 1, 0);
        chk("b2b_end", 70'(MEM_to_WB_valid), 70'd0);
        tick();

        // Forward masking.
        drive(0, 1, mk(32'h1c002000, 5'd7, 32'h55, 0, 0, 3'b000), 1, 0); tick();
        drive(0, 0, '0, 1, 0);
        chk("fwd_mask", 70'(MEM_forward[36:32]), 70'd0);
        tick();
        drive(0, 0, '0, 1, 0);
        chk("fwd_empty", 70'(MEM_forward[36:32]), 70'd0);
        tick();

        // Reset while stalled with a valid load.
        drive(0, 1, mk(32'h1c003000, 5'd8, 32'h0, 1, 1, 3'b000), 1, 0); tick();
        drive(1, 0, '0, 0, 32'h11111111); tick();
        drive(0, 0, '0, 1, 0);
        chk("rst_stall_valid", 70'(MEM_to_WB_valid), 70'd0);
        chk("rst_stall_allow", 70'(MEM_allow_in), 70'd1);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7),
                  mk($urandom, 5'($urandom), $urandom, 1'($urandom), 1'($urandom), 3'($urandom)),
                  ($urandom_range(0, 9) < 6),
                  $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, the transmitter side of the MEM→WB valid/allow-in handshake. Accepts one instruction per cycle from EX, picks up the data-SRAM read word for loads issued in EX, aligns and sign- or zero-extends it, and presents the packed writeback bus to WB. Also drives a forwarding bus for the ID-stage bypass network.

## Interface
- No parameters. Bus widths come from the shared constants header.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- to_MEM_data  in  74  {pc[31:0], dest[4:0], alu_result[31:0], gr_we, res_from_mem, ld_op[2:0]}, MSB first.
- EX_to_MEM_valid  in  1  EX holds a valid instruction.
- MEM_allow_in  out  1  MEM accepts from EX this cycle.
- data_sram_rdata  in  32  read data for a request issued by EX in the previous cycle.
- to_WB_data  out  70  {pc[31:0], dest[4:0], final_result[31:0], gr_we}.
- MEM_to_WB_valid  out  1  MEM presents a valid instruction.
- WB_allow_in  in  1  WB accepts this cycle.
- MEM_forward  out  37  {fwd_dest[4:0], final_result[31:0]}.

## Operation
- ready_go is constant 1. MEM_to_WB_valid = MEM_valid. MEM_allow_in = ~MEM_valid | WB_allow_in.
- On clock: if reset, MEM_valid←0 and first_cycle←0. Else if MEM_allow_in, MEM_valid←EX_to_MEM_valid. Payload register loads to_MEM_data on EX_to_MEM_valid & MEM_allow_in. Otherwise it holds.
- first_cycle is set on every accept and cleared on the next clock. data_sram_rdata is valid only while first_cycle=1.
- rdata hold: if first_cycle & MEM_valid & ~WB_allow_in, rdata_buf←data_sram_rdata. mem_word = first_cycle ? data_sram_rdata : rdata_buf.
- Load extraction uses a = alu_result[1:0]:
  - ld.w (3'b000): the whole word. a is ignored.
  - ld.b (001) / ld.bu (011): byte a, sign-extended / zero-extended.
  - ld.h (010) / ld.hu (100): halfword a[1], sign-extended / zero-extended. a[0] is ignored; misalignment is not checked here.
  - Codes 101–111: treated as ld.w.
- final_result = res_from_mem ? load_data : alu_result. to_WB_data packs the registered pc, dest and gr_we with final_result.
- fwd_dest = dest when MEM_valid & gr_we, else 5'd0. Dest 0 means "no forward".

## Timing
- Reset values: MEM_valid=0, MEM_to_WB_valid=0, MEM_allow_in=1, MEM_forward=37'b0 in its dest field (the data field is don't-care), first_cycle=0.
- Latency is one cycle EX→WB-presented when WB does not stall. Output is combinational from the registered state plus data_sram_rdata.
- Stall: while WB_allow_in=0 and MEM_valid=1, to_WB_data and MEM_forward stay bit-stable across cycles, including the load result (served from rdata_buf after the first cycle).
- Simultaneous leave and enter: with WB_allow_in=1 the old instruction moves to WB and the new one is captured in the same edge. first_cycle is re-set.
- A bubble (EX_to_MEM_valid=0 with MEM_allow_in=1) clears MEM_valid. Payload contents are then don't-care.
- Reset mid-stall drops the held instruction. The first cycle after reset presents MEM_to_WB_valid=0.

## Structure
- Shared constants header holds `to_MEM_data_width (74), `to_WB_data_width (70) and `forwrd_data_width (37), plus the ld_op codes `LD_W, `LD_B, `LD_H, `LD_BU and `LD_HU.
- Sub-module: load_align, combinational: (mem_word, addr[1:0], ld_op) → load_data[31:0]. It is reused by any future unaligned or exception logic.

## Test plan
- ALU passthrough: accept {pc=0x1c000000, dest=5, alu=0x12345678, gr_we=1, res_from_mem=0}, WB_allow_in=1 → next cycle MEM_to_WB_valid=1, final_result=0x12345678, MEM_forward dest=5.
- Load extension: rdata=0x80FF7F01, addr low bits 3 with ld.b → 0xFFFFFF80; with ld.bu → 0x00000080. Addr low bits 2 with ld.h → 0xFFFF80FF; with ld.hu → 0x000080FF. ld.w at addr 1 → 0x80FF7F01.
- Stall hold: ld.w accepted with rdata=0xDEADBEEF, WB_allow_in=0 for 3 cycles, and data_sram_rdata changed to 0x0 after the first cycle → final_result stays 0xDEADBEEF throughout and MEM_allow_in=0. Releasing the stall passes the instruction to WB once.
- Back-to-back: accept an instruction every cycle for 4 cycles with WB_allow_in=1 → 4 consecutive valid outputs in order with no duplicate or dropped pc.
- Forward masking: gr_we=0 with dest=7 → MEM_forward dest=0. Empty stage → dest=0.
- Reset while stalled with a valid load → next cycle MEM_to_WB_valid=0 and MEM_allow_in=1. The load never reaches WB.
